// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: single-cycle ops plus an iterative 1-bit/cycle shifter behind a valid/ready/done handshake.
// Define ALU_SHIFT_FAST_EN to replace the iterative shifter with a combinational barrel shifter.
module alu_multicycle_exec #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o,
   output logic                  branch_taken_o
);

   localparam int SW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_zero;
   logic                  r_taken;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [SW-1:0]         r_cnt;
   logic                  r_left;

   logic                  w_accept;
   logic                  w_is_shift;
   logic                  w_iter;
   logic [SW-1:0]         w_shamt;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_taken;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [DATA_WIDTH-1:0] w_diff;
   logic [DATA_WIDTH-1:0] w_shnext;

   assign w_accept   = valid_i && (r_state != S_SHIFT);
   assign w_shamt    = B_i[SW-1:0];
   assign w_is_shift = (ALU_Operation_i == 4'b0101) || (ALU_Operation_i == 4'b0111);
   assign w_sum      = A_i + B_i;
   assign w_diff     = A_i - B_i;
   assign w_shnext   = r_left ? (r_shreg << 1) : (r_shreg >> 1);

`ifdef ALU_SHIFT_FAST_EN
   assign w_iter = 1'b0;
`else
   assign w_iter = w_is_shift && (w_shamt != '0);
`endif

   always_comb begin
      w_res   = '0;
      w_taken = 1'b0;
      case (ALU_Operation_i)
         4'b0000: w_res = w_sum;
         4'b0001: w_res = w_diff;
         4'b0010: w_res = A_i ^ B_i;
         4'b0011: w_res = A_i | B_i;
         4'b1000: w_res = A_i | B_i;
         4'b0100: w_res = A_i & B_i;
`ifdef ALU_SHIFT_FAST_EN
         4'b0101: w_res = A_i << w_shamt;
         4'b0111: w_res = A_i >> w_shamt;
`else
         // Only the zero-shift case completes here; nonzero shifts run in S_SHIFT.
         4'b0101: w_res = A_i;
         4'b0111: w_res = A_i;
`endif
         4'b1101: w_res = w_sum;
         4'b1100: w_res = w_sum;
         4'b1001: w_res = B_i;
         4'b1010: w_res = w_sum & ~DATA_WIDTH'(1);
         4'b1011: begin
            w_res   = w_diff;
            w_taken = (A_i == B_i);
         end
         4'b1110: begin
            w_res   = w_diff;
            w_taken = (A_i != B_i);
         end
         4'b1111: begin
            w_res   = w_diff;
            w_taken = ($signed(A_i) < $signed(B_i));
         end
         default: begin
            w_res   = '0;
            w_taken = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = w_iter ? S_SHIFT : S_DONE;
            else          w_next = S_IDLE;
         end
         S_SHIFT: begin
            if (r_cnt == SW'(1)) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_taken  <= 1'b0;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_left   <= 1'b0;
      end else if (w_accept && !w_iter) begin
         r_result <= w_res;
         r_zero   <= (w_res == '0);
         r_taken  <= w_taken;
      end else if (w_accept) begin
         r_shreg <= A_i;
         r_cnt   <= w_shamt;
         r_left  <= (ALU_Operation_i == 4'b0101);
      end else if (r_state == S_SHIFT) begin
         r_shreg <= w_shnext;
         r_cnt   <= r_cnt - SW'(1);
         if (r_cnt == SW'(1)) begin
            r_result <= w_shnext;
            r_zero   <= (w_shnext == '0);
            r_taken  <= 1'b0;
         end
      end
   end

   assign ready_o        = (r_state != S_SHIFT);
   assign done_o         = (r_state == S_DONE);
   assign result_o       = r_result;
   assign zero_o         = r_zero;
   assign branch_taken_o = r_taken;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Scoreboard bench for alu_multicycle_exec: stimulus pushes expectations, a negedge monitor checks each done_o.
module tb_alu_multicycle_exec;

   localparam int DW = 32;
`ifdef ALU_SHIFT_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid_i = 1'b0;
   logic [3:0]    op = 4'd0;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] b = '0;
   logic          ready_o, done_o, zero_o, branch_taken_o;
   logic [DW-1:0] result_o;

   typedef struct {
      logic [DW-1:0] res;
      logic          z;
      logic          t;
      int            dly;
      int            acc_cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   alu_multicycle_exec #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .ALU_Operation_i(op),
      .A_i(a), .B_i(b), .ready_o(ready_o), .done_o(done_o),
      .result_o(result_o), .zero_o(zero_o), .branch_taken_o(branch_taken_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every done_o must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done_o) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done_o=1 expected no pending op (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result_o, e.res);
            check("zero", DW'(zero_o), DW'(e.z));
            check("taken", DW'(branch_taken_o), DW'(e.t));
            check("latency", DW'(cyc - e.acc_cyc), DW'(e.dly));
         end
      end
   end

   function automatic int sdly(input int n);
      return FAST ? 0 : n;
   endfunction

   // Drive a request at negedge once ready; valid_i is left high for back-to-back use.
   task automatic send(input logic [3:0] o, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [DW-1:0] res, input logic t, input int dly, input bit push);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got ready_o=0 expected 1");
      end
      valid_i = 1'b1;
      op = o;
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      if (push) begin
         e.res = res;
         e.z = (res == '0);
         e.t = t;
         e.dly = dly;
         e.acc_cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      idle();
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #12;
      check("rst_ready", DW'(ready_o), DW'(1));
      check("rst_done", DW'(done_o), DW'(0));
      check("rst_result", result_o, '0);
      check("rst_zero", DW'(zero_o), DW'(1));
      @(negedge clk);
      reset = 1'b0;

      send(4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1); idle();
      send(4'b0001, 32'd7, 32'd7, 32'd0, 1'b0, 0, 1); idle();
      send(4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 0, 1); idle();
      send(4'b0011, 32'h00001200, 32'h00000034, 32'h00001234, 1'b0, 0, 1); idle();
      send(4'b1000, 32'h1, 32'h2, 32'h3, 1'b0, 0, 1); idle();
      send(4'b0100, 32'h0000FF0F, 32'h00000FF0, 32'h00000F00, 1'b0, 0, 1); idle();
      send(4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 0, 1); idle();
      send(4'b1101, 32'h100, 32'h20, 32'h120, 1'b0, 0, 1); idle();
      send(4'b1100, 32'h10, 32'hFFFFFFFC, 32'hC, 1'b0, 0, 1); idle();
      send(4'b1001, 32'h5, 32'h12345000, 32'h12345000, 1'b0, 0, 1); idle();
      send(4'b1010, 32'h101, 32'h0, 32'h100, 1'b0, 0, 1); idle();
      send(4'b1011, 32'd3, 32'd3, 32'd0, 1'b1, 0, 1); idle();
      send(4'b1110, 32'd3, 32'd3, 32'd0, 1'b0, 0, 1); idle();
      send(4'b1110, 32'd5, 32'd3, 32'd2, 1'b1, 0, 1); idle();
      send(4'b1111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1, 0, 1); idle();
      send(4'b1111, 32'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 1); idle();
      send(4'b0110, 32'h55, 32'h66, 32'h0, 1'b0, 0, 1); idle();
      drain();

      send(4'b0101, 32'h1, 32'd4, 32'h10, 1'b0, sdly(4), 1); idle();
      @(negedge clk);
      check("ready_during_shift", DW'(ready_o), DW'(FAST ? 1 : 0));
      drain();

      // Operands presented mid-shift must be ignored.
      send(4'b0111, 32'h80000000, 32'd31, 32'h1, 1'b0, sdly(31), 1);
      op = 4'b0000; a = 32'd9; b = 32'd9;
      if (FAST) idle();
      repeat (3) @(negedge clk);
      idle();
      drain();

      send(4'b0111, 32'h1234, 32'd0, 32'h1234, 1'b0, 0, 1); idle();
      send(4'b0101, 32'h3, 32'd37, 32'h60, 1'b0, sdly(5), 1); idle();
      send(4'b0101, 32'h1, 32'd31, 32'h80000000, 1'b0, sdly(31), 1); idle();
      drain();

      send(4'b0010, 32'hA, 32'h5, 32'hF, 1'b0, 0, 1);
      send(4'b0100, 32'hC, 32'hA, 32'h8, 1'b0, 0, 1);
      idle();
      drain();

      if (!FAST) begin
         send(4'b0101, 32'h1, 32'd20, 32'h0, 1'b0, 0, 0); idle();
         repeat (5) @(negedge clk);
         reset = 1'b1;
         #1;
         check("midrst_ready", DW'(ready_o), DW'(1));
         check("midrst_done", DW'(done_o), DW'(0));
         check("midrst_result", result_o, '0);
         check("midrst_zero", DW'(zero_o), DW'(1));
         check("midrst_taken", DW'(branch_taken_o), DW'(0));
         @(negedge clk);
         reset = 1'b0;
         repeat (30) @(negedge clk);
      end

      send(4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 0, 1); idle();
      drain();
      check("queue_empty", DW'(q.size()), DW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
